// File: rtl/crc_req_arbiter_if.sv
// Bundle between requesters, result consumer and the shared CRC engine.
// The arbiter uses the slave view; the surrounding system uses master.
interface crc_req_arbiter_if #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CRC_WIDTH = 8,
    parameter int unsigned DWIDTH    = 16
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]           reqValid;
    logic [NREQ*DWIDTH-1:0]    reqData;
    logic [NREQ*CRC_WIDTH-1:0] reqPoly;
    logic [NREQ-1:0]           reqReady;
    logic                      rspValid;
    logic                      rspReady;
    logic [IDW-1:0]            rspId;
    logic [CRC_WIDTH-1:0]      rspCrc;
    logic                      rspErr;
    logic                      engCtrlEn;
    logic [DWIDTH-1:0]         engDataIn;
    logic [CRC_WIDTH-1:0]      engGenPoly;
    logic [CRC_WIDTH-1:0]      engCrcSeq;
    logic                      engCrcReady;

    modport slave (
        input  reqValid, reqData, reqPoly, rspReady, engCrcSeq, engCrcReady,
        output reqReady, rspValid, rspId, rspCrc, rspErr, engCtrlEn, engDataIn, engGenPoly
    );

    modport master (
        output reqValid, reqData, reqPoly, rspReady, engCrcSeq, engCrcReady,
        input  reqReady, rspValid, rspId, rspCrc, rspErr, engCtrlEn, engDataIn, engGenPoly
    );
endinterface

// File: rtl/crc_req_arbiter.sv
// Round-robin front end that shares one serial CRC engine between NREQ clients,
// running one job at a time with a per-job timeout against a hung engine.
module crc_req_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CRC_WIDTH = 8,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned TIMEOUT   = DWIDTH + 4
) (
    input  logic              clk,
    input  logic              rstN,
    crc_req_arbiter_if.slave  bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e               state_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       id_q;
    logic [DWIDTH-1:0]    data_q;
    logic [CRC_WIDTH-1:0] poly_q;
    logic [CRC_WIDTH-1:0] crc_q;
    logic                 err_q;
    logic                 rsp_valid_q;
    logic                 ctrl_en_q;
    logic [TW-1:0]        timer_q;

    logic                 grant_vld_c;
    logic [IDW-1:0]       grant_id_c;
    logic [NREQ-1:0]      req_ready_c;

    // First pending requester after the last winner, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        req_ready_c = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld_c && bus.reqValid[IDW'(idx)]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = IDW'(idx);
            end
        end
        if (state_q == IDLE && bus.engCrcReady && grant_vld_c) begin
            req_ready_c[grant_id_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            data_q      <= '0;
            poly_q      <= '0;
            crc_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            ctrl_en_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            ctrl_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_ready_c) begin
                        id_q      <= grant_id_c;
                        data_q    <= bus.reqData[32'(grant_id_c) * DWIDTH +: DWIDTH];
                        poly_q    <= bus.reqPoly[32'(grant_id_c) * CRC_WIDTH +: CRC_WIDTH];
                        rr_ptr_q  <= grant_id_c;
                        ctrl_en_q <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                // Engine already dropped ready when it saw the start pulse,
                // so a high ready here always means the job is finished.
                WAIT: begin
                    if (bus.engCrcReady) begin
                        crc_q       <= bus.engCrcSeq;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        crc_q       <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    if (bus.rspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.reqReady   = req_ready_c;
    assign bus.rspValid   = rsp_valid_q;
    assign bus.rspId      = id_q;
    assign bus.rspCrc     = crc_q;
    assign bus.rspErr     = err_q;
    assign bus.engCtrlEn  = ctrl_en_q;
    assign bus.engDataIn  = data_q;
    assign bus.engGenPoly = poly_q;
endmodule

// File: tb/tb_crc_req_arbiter.sv
// Directed and randomized checks of crc_req_arbiter against a simple engine
// model and a round-robin reference kept in the bench.
module tb_crc_req_arbiter;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned CRC_WIDTH = 8;
    localparam int unsigned DWIDTH    = 16;
    localparam int unsigned TIMEOUT   = DWIDTH + 4;

    logic clk;
    logic rstN;

    crc_req_arbiter_if #(.NREQ(NREQ), .CRC_WIDTH(CRC_WIDTH), .DWIDTH(DWIDTH)) bus ();

    crc_req_arbiter #(
        .NREQ(NREQ), .CRC_WIDTH(CRC_WIDTH), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ*DWIDTH-1:0]    req_data_flat;
    logic [NREQ*CRC_WIDTH-1:0] req_poly_flat;
    logic                      rsp_ready;

    assign bus.reqValid = req_valid;
    assign bus.reqData  = req_data_flat;
    assign bus.reqPoly  = req_poly_flat;
    assign bus.rspReady = rsp_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_g   = 0;
    int rr_m     = NREQ - 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in engine result: any fixed function of data and polynomial will do.
    function automatic logic [CRC_WIDTH-1:0] eng_fn(input logic [DWIDTH-1:0] d,
                                                    input logic [CRC_WIDTH-1:0] p);
        return d[15:8] ^ d[7:0] ^ p ^ 8'h84;
    endfunction

    // Engine model: busy DWIDTH cycles after a start pulse; can be made to hang.
    int                   eng_cnt    = 0;
    logic                 eng_hang   = 1'b0;
    logic                 eng_hung_q = 1'b0;
    logic [CRC_WIDTH-1:0] eng_res    = '0;

    always @(posedge clk) begin
        if (bus.engCtrlEn) begin
            eng_cnt    <= DWIDTH;
            eng_hung_q <= eng_hang;
            eng_res    <= eng_fn(bus.engDataIn, bus.engGenPoly);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    assign bus.engCrcReady = (eng_cnt == 0) && !(eng_hung_q && eng_hang);
    assign bus.engCrcSeq   = eng_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [DWIDTH-1:0] d, input logic [CRC_WIDTH-1:0] p);
        req_data_flat[i*DWIDTH +: DWIDTH]       = d;
        req_poly_flat[i*CRC_WIDTH +: CRC_WIDTH] = p;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rspValid"},   32'(bus.rspValid),   0);
        chk({tag, "_rspErr"},     32'(bus.rspErr),     0);
        chk({tag, "_rspCrc"},     32'(bus.rspCrc),     0);
        chk({tag, "_rspId"},      32'(bus.rspId),      0);
        chk({tag, "_engCtrlEn"},  32'(bus.engCtrlEn),  0);
        chk({tag, "_engDataIn"},  32'(bus.engDataIn),  0);
        chk({tag, "_engGenPoly"}, 32'(bus.engGenPoly), 0);
        chk({tag, "_reqReady"},   32'(bus.reqReady),   0);
    endtask

    // One full job seen from the grant cycle to the cycle after the response is taken.
    task automatic do_job(input int id, input int hold, input bit hung, input bit keep, input bit space);
        int n;
        int g0;
        logic [DWIDTH-1:0]    d;
        logic [CRC_WIDTH-1:0] p;
        logic [CRC_WIDTH-1:0] exp_crc;
        n = 0;
        #1;
        while (bus.reqReady == '0 && n < 60) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", 32'(bus.reqReady), 32'(1) << id);
        g0 = cyc;
        if (space) chk("job_spacing", 32'(g0 - last_g), DWIDTH + 4);
        last_g  = g0;
        d       = req_data_flat[id*DWIDTH +: DWIDTH];
        p       = req_poly_flat[id*CRC_WIDTH +: CRC_WIDTH];
        exp_crc = hung ? '0 : eng_fn(d, p);
        if (hold > 0) rsp_ready = 1'b0;
        @(negedge clk);
        if (!keep) req_valid[id] = 1'b0;
        #1;
        chk("launch_ctrlEn",   32'(bus.engCtrlEn),  1);
        chk("launch_reqReady", 32'(bus.reqReady),   0);
        chk("launch_data",     32'(bus.engDataIn),  32'(d));
        chk("launch_poly",     32'(bus.engGenPoly), 32'(p));
        n = 0;
        while (!bus.rspValid && n < 60) begin
            @(negedge clk); #1; n++;
        end
        chk("rsp_latency", 32'(cyc - g0), hung ? TIMEOUT + 2 : DWIDTH + 3);
        chk("rsp_id",  32'(bus.rspId),  32'(id));
        chk("rsp_crc", 32'(bus.rspCrc), 32'(exp_crc));
        chk("rsp_err", 32'(bus.rspErr), 32'(hung));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("bp_valid",    32'(bus.rspValid), 1);
            chk("bp_crc",      32'(bus.rspCrc),   32'(exp_crc));
            chk("bp_reqReady", 32'(bus.reqReady), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("rsp_drop", 32'(bus.rspValid), 0);
        rr_m = id;
    endtask

    task automatic do_reset();
        rstN      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rstN = 1'b1;
        rr_m = NREQ - 1;
    endtask

    initial begin
        int n;
        int id;
        rstN          = 1'b0;
        req_valid     = '0;
        req_data_flat = '0;
        req_poly_flat = '0;
        rsp_ready     = 1'b1;
        @(negedge clk);
        do_reset();

        // T1 single job
        set_req(0, 16'h1234, 8'h07);
        req_valid = 4'b0001;
        do_job(0, 0, 0, 0, 0);

        // T2 all requesters held, back-to-back order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 8'($urandom));
        req_valid = 4'b1111;
        do_job(0, 0, 0, 1, 0);
        do_job(1, 0, 0, 1, 1);
        do_job(2, 0, 0, 1, 1);
        do_job(3, 0, 0, 1, 1);
        do_job(0, 0, 0, 1, 1);

        // T3 only 1 and 3 requesting: alternate between them
        req_valid = 4'b1010;
        do_job(1, 0, 0, 1, 0);
        do_job(3, 0, 0, 1, 0);
        do_job(1, 0, 0, 1, 0);
        req_valid = '0;

        // T4 response backpressure with another request pending
        set_req(2, 16'hBEEF, 8'h31);
        set_req(0, 16'h0F0F, 8'h9B);
        req_valid = 4'b0101;
        do_job(2, 10, 0, 0, 0);
        do_job(0, 0, 0, 0, 0);

        // T5 hung engine times out; next grant waits for engine ready
        eng_hang = 1'b1;
        set_req(1, 16'hCAFE, 8'h1D);
        req_valid = 4'b0010;
        do_job(1, 0, 1, 0, 0);
        set_req(3, 16'h5A5A, 8'hE7);
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hung_no_grant", 32'(bus.reqReady), 0);
        end
        eng_hang = 1'b0;
        do_job(3, 0, 0, 0, 0);

        // T6 reset in the middle of WAIT
        set_req(1, 16'h7777, 8'h2F);
        req_valid = 4'b0010;
        n = 0;
        #1;
        while (bus.reqReady == '0 && n < 60) begin
            @(negedge clk); #1; n++;
        end
        chk("t6_grant", 32'(bus.reqReady), 32'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        do_reset();
        set_req(0, 16'hA0A0, 8'h55);
        set_req(3, 16'h0303, 8'hC1);
        req_valid = 4'b1001;
        do_job(0, 0, 0, 0, 0);
        do_job(3, 0, 0, 0, 0);

        // Randomized traffic against the round-robin reference
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, 16'($urandom), 8'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                id = int'($urandom_range(0, NREQ - 1));
                set_req(id, 16'($urandom), 8'($urandom));
                req_valid[id] = 1'b1;
            end
            id = model_grant(req_valid, rr_m);
            do_job(id, int'($urandom_range(0, 3)), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
